// File: rtl/packet_switch_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// switch_pkg : shared FSM encoding and constants for packet_switch_arbiter
// Rev 1.0
// ==========================================================================
package switch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORWARD = 2'd1,
      DROP    = 2'd2
   } state_t;

   // Metadata value the parser emits for protocols it cannot classify
   localparam logic [31:0] INVALID_IP    = 32'h0;
   localparam int          ETH_MIN_BYTES = 60;

endpackage
`default_nettype wire

// File: rtl/packet_switch_arbiter_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : combinational rotating-priority select, first request at or after ptr
// Rev 1.0
// ==========================================================================
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any_grant
);

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // Scan from farthest to nearest so the request closest to ptr wins last
   always_comb begin
      grant = '0;
      sum   = '0;
      idx   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         sum = {1'b0, ptr} + (W+1)'(off);
         if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
         end
         idx = sum[W-1:0];
         if (req[idx]) begin
            grant = idx;
         end
      end
      any_grant = |req;
   end

endmodule
`default_nettype wire

// File: rtl/packet_switch_arbiter.sv
`default_nettype none
// ==========================================================================
// packet_switch_arbiter : round-robin packet scheduler, N_IN queues -> one byte stream
// Rev 1.0
// ==========================================================================
module packet_switch_arbiter
   import switch_pkg::*;
#(
   parameter int N_IN         = 4,
   parameter int SRC_W        = 2,
   parameter bit DROP_ZERO_IP = 1'b1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [N_IN-1:0]     in_meta_tvalid,
   input  logic [32*N_IN-1:0]  in_meta_tdata,
   output logic [N_IN-1:0]     in_meta_tready,
   input  logic [N_IN-1:0]     in_data_tvalid,
   input  logic [8*N_IN-1:0]   in_data_tdata,
   input  logic [N_IN-1:0]     in_data_tlast,
   output logic [N_IN-1:0]     in_data_tready,
   output logic                out_axis_tvalid,
   output logic [7:0]          out_axis_tdata,
   output logic                out_axis_tlast,
   input  logic                out_axis_tready,
   output logic [31:0]         out_dest_ip,
   output logic [SRC_W-1:0]    out_src,
   output logic                busy,
   output logic [31:0]         forwarded_count,
   output logic [31:0]         dropped_count
);

   state_t            state_q,    state_d;
   logic [SRC_W-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [SRC_W-1:0]  src_q,      src_d;
   logic [31:0]       dest_ip_q,  dest_ip_d;
   logic [31:0]       fwd_cnt_q,  fwd_cnt_d;
   logic [31:0]       drop_cnt_q, drop_cnt_d;

   logic [SRC_W-1:0]  grant;
   logic              any_grant;
   logic [31:0]       grant_ip;
   logic              beat_valid;
   logic              beat_last;
   logic [SRC_W-1:0]  next_ptr;

   rr_arbiter #(
      .N (N_IN),
      .W (SRC_W)
   ) u_rr_arbiter (
      .req       (in_meta_tvalid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .any_grant (any_grant)
   );

   assign grant_ip   = in_meta_tdata[32*grant +: 32];
   assign beat_valid = in_data_tvalid[src_q];
   assign beat_last  = in_data_tlast[src_q];
   assign next_ptr   = (src_q == SRC_W'(N_IN - 1)) ? '0 : src_q + 1'b1;

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      src_d           = src_q;
      dest_ip_d       = dest_ip_q;
      fwd_cnt_d       = fwd_cnt_q;
      drop_cnt_d      = drop_cnt_q;
      in_meta_tready  = '0;
      in_data_tready  = '0;
      out_axis_tvalid = 1'b0;
      out_axis_tdata  = 8'h00;
      out_axis_tlast  = 1'b0;

      case (state_q)
         IDLE: begin
            // Pop is combinational so the grant and the metadata word are taken together
            if (any_grant) begin
               in_meta_tready[grant] = 1'b1;
               src_d                 = grant;
               dest_ip_d             = grant_ip;
               state_d = (DROP_ZERO_IP && (grant_ip == INVALID_IP)) ? DROP : FORWARD;
            end
         end
         FORWARD: begin
            out_axis_tvalid       = beat_valid;
            out_axis_tdata        = in_data_tdata[8*src_q +: 8];
            out_axis_tlast        = beat_last;
            in_data_tready[src_q] = out_axis_tready;
            if (beat_valid && out_axis_tready && beat_last) begin
               fwd_cnt_d = fwd_cnt_q + 32'd1;
               rr_ptr_d  = next_ptr;
               state_d   = IDLE;
            end
         end
         DROP: begin
            in_data_tready[src_q] = 1'b1;
            if (beat_valid && beat_last) begin
               drop_cnt_d = drop_cnt_q + 32'd1;
               rr_ptr_d   = next_ptr;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         src_q      <= '0;
         dest_ip_q  <= 32'h0;
         fwd_cnt_q  <= 32'h0;
         drop_cnt_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         src_q      <= src_d;
         dest_ip_q  <= dest_ip_d;
         fwd_cnt_q  <= fwd_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_dest_ip     = dest_ip_q;
   assign out_src         = src_q;
   assign busy            = (state_q != IDLE);
   assign forwarded_count = fwd_cnt_q;
   assign dropped_count   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_switch_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_packet_switch_arbiter : directed table-driven bench with queue models
// Rev 1.0
// ==========================================================================
module tb_packet_switch_arbiter;
   import switch_pkg::*;

   localparam int N  = 4;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              resetn;
   logic [N-1:0]      in_meta_tvalid;
   logic [32*N-1:0]   in_meta_tdata;
   logic [N-1:0]      in_meta_tready;
   logic [N-1:0]      in_data_tvalid;
   logic [8*N-1:0]    in_data_tdata;
   logic [N-1:0]      in_data_tlast;
   logic [N-1:0]      in_data_tready;
   logic              out_axis_tvalid;
   logic [7:0]        out_axis_tdata;
   logic              out_axis_tlast;
   logic              out_axis_tready;
   logic [31:0]       out_dest_ip;
   logic [SW-1:0]     out_src;
   logic              busy;
   logic [31:0]       forwarded_count;
   logic [31:0]       dropped_count;

   packet_switch_arbiter #(
      .N_IN         (N),
      .SRC_W        (SW),
      .DROP_ZERO_IP (1'b1)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .in_meta_tvalid  (in_meta_tvalid),
      .in_meta_tdata   (in_meta_tdata),
      .in_meta_tready  (in_meta_tready),
      .in_data_tvalid  (in_data_tvalid),
      .in_data_tdata   (in_data_tdata),
      .in_data_tlast   (in_data_tlast),
      .in_data_tready  (in_data_tready),
      .out_axis_tvalid (out_axis_tvalid),
      .out_axis_tdata  (out_axis_tdata),
      .out_axis_tlast  (out_axis_tlast),
      .out_axis_tready (out_axis_tready),
      .out_dest_ip     (out_dest_ip),
      .out_src         (out_src),
      .busy            (busy),
      .forwarded_count (forwarded_count),
      .dropped_count   (dropped_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          q;
      logic [31:0] ip;
      int          len;
      int          beats;
      int          fwd;
      int          drop;
   } vec_t;

   logic [31:0] meta_q [N][$];
   logic [8:0]  data_q [N][$];
   logic [8:0]  out_log [$];
   int          grant_log [$];
   int          meta_pops [N];
   logic [N-1:0] s_dready;
   logic        s_busy;
   logic        s_otready;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_fronts();
      logic [8:0] d;
      for (int i = 0; i < N; i++) begin
         in_meta_tvalid[i]        = (meta_q[i].size() != 0);
         in_meta_tdata[32*i +: 32] = in_meta_tvalid[i] ? meta_q[i][0] : 32'h0;
         in_data_tvalid[i]        = (data_q[i].size() != 0);
         d = in_data_tvalid[i] ? data_q[i][0] : 9'h0;
         in_data_tdata[8*i +: 8]  = d[7:0];
         in_data_tlast[i]         = d[8];
      end
   endtask

   // Handshakes are judged at the falling edge, then applied just after the rising edge
   task automatic tick();
      logic [N-1:0] mp, dp;
      logic         ob, rst_now;
      logic [8:0]   ob_beat;
      @(negedge clk);
      mp        = in_meta_tvalid & in_meta_tready;
      dp        = in_data_tvalid & in_data_tready;
      ob        = out_axis_tvalid & out_axis_tready;
      ob_beat   = {out_axis_tlast, out_axis_tdata};
      rst_now   = !resetn;
      s_dready  = in_data_tready;
      s_busy    = busy;
      s_otready = out_axis_tready;
      @(posedge clk);
      #1;
      if (rst_now) begin
         for (int i = 0; i < N; i++) begin
            meta_q[i].delete();
            data_q[i].delete();
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (mp[i]) begin
               void'(meta_q[i].pop_front());
               meta_pops[i]++;
               grant_log.push_back(i);
            end
            if (dp[i]) void'(data_q[i].pop_front());
         end
         if (ob) out_log.push_back(ob_beat);
      end
      drive_fronts();
   endtask

   task automatic push_pkt(input int q, input logic [31:0] ip, input int len, input int base);
      meta_q[q].push_back(ip);
      for (int k = 0; k < len; k++) begin
         data_q[q].push_back({(k == len - 1), 8'(base + k)});
      end
      drive_fronts();
   endtask

   task automatic run_to_idle(input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while ((busy || (in_meta_tvalid != '0)) && cycles < budget);
      if (busy || (in_meta_tvalid != '0)) check("timeout", 32'd1, 32'd0);
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      grant_log.delete();
      out_log.delete();
   endtask

   // Counts beats of out_log that differ from a packet built as base+k, tlast on the final byte
   function automatic int diff_pkt(input int off, input int len, input int base);
      logic [8:0] e;
      int bad = 0;
      for (int k = 0; k < len; k++) begin
         e = {(k == len - 1), 8'(base + k)};
         if (off + k >= out_log.size()) bad++;
         else if (out_log[off + k] !== e) bad++;
      end
      return bad;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   vec_t vecs [5];
   int   cyc, pops0, bad, mm, k;

   initial begin
      vecs[0] = '{1, 32'h0A00_0002, 64, 64, 1, 0};
      vecs[1] = '{2, 32'h0000_0000, 20, 0, 1, 1};
      vecs[2] = '{0, 32'hC0A8_0001, 1, 1, 2, 1};
      vecs[3] = '{3, 32'hFFFF_FFFF, ETH_MIN_BYTES, ETH_MIN_BYTES, 3, 1};
      vecs[4] = '{2, 32'h0000_0000, 1, 0, 3, 2};

      resetn          = 1'b0;
      out_axis_tready = 1'b1;
      for (int i = 0; i < N; i++) meta_pops[i] = 0;
      drive_fronts();
      tick();
      tick();
      resetn = 1'b1;

      check("rst_busy",     32'(busy), 32'd0);
      check("rst_tvalid",   32'(out_axis_tvalid), 32'd0);
      check("rst_src",      32'(out_src), 32'd0);
      check("rst_dest_ip",  out_dest_ip, 32'h0);
      check("rst_fwd_cnt",  forwarded_count, 32'd0);
      check("rst_drop_cnt", dropped_count, 32'd0);

      // Data present with no metadata must stay stalled
      data_q[0].push_back(9'h011);
      data_q[0].push_back(9'h112);
      drive_fronts();
      tick();
      tick();
      check("nometa_dready", 32'(s_dready), 32'd0);
      check("nometa_kept",   32'(data_q[0].size()), 32'd2);
      data_q[0].delete();
      drive_fronts();

      for (int v = 0; v < 5; v++) begin
         out_log.delete();
         pops0 = meta_pops[vecs[v].q];
         push_pkt(vecs[v].q, vecs[v].ip, vecs[v].len, 16 * v);
         run_to_idle(300, cyc);
         check($sformatf("v%0d_src", v),      32'(out_src), 32'(vecs[v].q));
         check($sformatf("v%0d_dest_ip", v),  out_dest_ip, vecs[v].ip);
         check($sformatf("v%0d_fwd_cnt", v),  forwarded_count, 32'(vecs[v].fwd));
         check($sformatf("v%0d_drop_cnt", v), dropped_count, 32'(vecs[v].drop));
         check($sformatf("v%0d_cycles", v),   32'(cyc), 32'(vecs[v].len + 1));
         check($sformatf("v%0d_beats", v),    32'(out_log.size()), 32'(vecs[v].beats));
         check($sformatf("v%0d_pops", v),     32'(meta_pops[vecs[v].q] - pops0), 32'd1);
         check($sformatf("v%0d_drained", v),  32'(data_q[vecs[v].q].size()), 32'd0);
         if (vecs[v].beats != 0) begin
            check($sformatf("v%0d_data", v), 32'(diff_pkt(0, vecs[v].len, 16 * v)), 32'd0);
         end
      end

      // Round robin from pointer 0 across all queues, one idle cycle per packet
      reset_dut();
      for (int i = 0; i < N; i++) push_pkt(i, 32'h0A00_0100 + 32'(i), 4, 'h40 * i);
      run_to_idle(100, cyc);
      check("rr_cycles", 32'(cyc), 32'd20);
      check("rr_ngrants", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < N; i++) begin
         if (i < grant_log.size()) check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i));
         check($sformatf("rr_pkt%0d", i), 32'(diff_pkt(4 * i, 4, 'h40 * i)), 32'd0);
      end
      check("rr_fwd_cnt", forwarded_count, 32'd4);

      // Backpressure 1,0,0,1 on a 16-byte packet while queue 3 holds unrequested data
      data_q[3].push_back(9'h0AA);
      data_q[3].push_back(9'h0AB);
      data_q[3].push_back(9'h1AC);
      push_pkt(1, 32'h0A00_0201, 16, 'h80);
      out_log.delete();
      k  = 0;
      mm = 0;
      do begin
         out_axis_tready = (k % 4 == 0) || (k % 4 == 3);
         tick();
         k++;
         if (s_busy && (s_dready != (s_otready ? 4'b0010 : 4'b0000))) mm++;
      end while ((busy || (in_meta_tvalid != '0)) && k < 200);
      out_axis_tready = 1'b1;
      check("bp_timeout",  32'(busy), 32'd0);
      check("bp_dready",   32'(mm), 32'd0);
      check("bp_beats",    32'(out_log.size()), 32'd16);
      check("bp_data",     32'(diff_pkt(0, 16, 'h80)), 32'd0);
      check("bp_q3_held",  32'(data_q[3].size()), 32'd3);
      check("bp_fwd_cnt",  forwarded_count, 32'd5);

      // Queue 3 requests once while queue 0 is busy: it goes next
      reset_dut();
      for (int j = 0; j < 3; j++) push_pkt(0, 32'h0A00_0010 + 32'(j), 3, 'h10 * j);
      tick();
      push_pkt(3, 32'h0A00_0003, 2, 'hE0);
      run_to_idle(100, cyc);
      check("fair_ngrants", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         check("fair_g0", 32'(grant_log[0]), 32'd0);
         check("fair_g1", 32'(grant_log[1]), 32'd3);
         check("fair_g2", 32'(grant_log[2]), 32'd0);
         check("fair_g3", 32'(grant_log[3]), 32'd0);
      end
      check("fair_fwd_cnt", forwarded_count, 32'd4);

      // Reset in the middle of a forwarded packet
      push_pkt(2, 32'h0A00_0020, 10, 'h30);
      for (int j = 0; j < 4; j++) tick();
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_src",  32'(out_src), 32'd2);
      reset_dut();
      check("mrst_busy",     32'(busy), 32'd0);
      check("mrst_src",      32'(out_src), 32'd0);
      check("mrst_dest_ip",  out_dest_ip, 32'h0);
      check("mrst_fwd_cnt",  forwarded_count, 32'd0);
      check("mrst_drop_cnt", dropped_count, 32'd0);
      check("mrst_mready",   32'(in_meta_tready), 32'd0);
      check("mrst_dready",   32'(in_data_tready), 32'd0);
      check("mrst_tvalid",   32'(out_axis_tvalid), 32'd0);
      push_pkt(3, 32'h0A00_0033, 1, 'h50);
      push_pkt(0, 32'h0A00_0030, 1, 'h60);
      tick();
      check("mrst_ptr_src", 32'(out_src), 32'd0);
      run_to_idle(50, cyc);
      check("mrst_fwd_after", forwarded_count, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
